flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer end of the ALU flag interface. Captures N/Z/V/C from the EX-stage ALU on flag-setting instructions (ADDS/SUBS) into an architectural NZCV register.
- Evaluates B.cond, CBZ and unconditional B in the ID stage, forwarding EX flags when needed.
- Issues a registered branch-taken redirect to fetch, and squashes the one shadow instruction that follows a taken branch.

Parameters:
- CNT_W, 16, width of the saturating taken-branch counter (performance visibility).

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high
- alu_negative  input  1  ALU negative flag, EX stage
- alu_zero  input  1  ALU zero flag, EX stage
- alu_overflow  input  1  ALU overflow flag, EX stage
- alu_carry_out  input  1  ALU carry-out flag, EX stage
- ex_valid  input  1  EX holds a live instruction
- ex_set_flags  input  1  EX instruction writes NZCV
- id_valid  input  1  ID holds a live instruction
- id_br_type  input  2  00 none, 01 B, 10 B.cond, 11 CBZ
- id_cond  input  4  ARM condition code for B.cond
- id_rt_zero  input  1  forwarded Rt==0 for CBZ
- flags_q  output  4  architectural {N,Z,C,V}
- br_taken  output  1  registered redirect, 1-cycle pulse
- squash  output  1  current ID instruction is a shadow; must be flushed
- taken_cnt  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async, active-high): flags_q=0000, br_taken=0, squash=0, taken_cnt=0, FSM=RUN.
- Flag capture: on posedge, if ex_valid & ex_set_flags & !squash_ex, then flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}. Otherwise hold.
- squash_ex: internal 1-cycle delayed copy of squash. A squashed instruction reaching EX never writes flags.
- Effective flags (combinational): EX flags when ex_valid & ex_set_flags & !squash_ex, else flags_q. Back-to-back SUBS then B.cond therefore resolves with zero stall.
- Condition table:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110/1111 always true.
- Decision (combinational, ID): take = id_valid & !squash & one of:
  - type 01 → 1
  - type 10 → cond(eff flags)
  - type 11 → id_rt_zero
  - type 00 → 0
- FSM, two states:
  - RUN: squash=0. If take: br_taken <= 1 next cycle, go SHADOW.
  - SHADOW: squash=1 for exactly one cycle. The ID decision is forced 0 regardless of inputs. br_taken <= 0. Return to RUN.
  - A branch directly behind a taken branch is therefore never taken.
- Latency: take evaluated in cycle t → br_taken high in cycle t+1 only. squash is high in t+1.
- taken_cnt: increments on each br_taken pulse; saturates at all-ones, no wrap.
- Simultaneous events:
  - Flag-setting EX and B.cond in ID in the same cycle: the forwarded EX flags win.
  - The flags_q update and the decision occur in the same edge without conflict.
- Reset asserted mid-SHADOW: immediate return to RUN, outputs cleared asynchronously. The first post-reset ID instruction is not squashed.
- id_valid=0: no decision, no FSM transition.

Test Plan:
- Reset: assert reset mid-cycle → flags_q=0000, br_taken=0, squash=0, taken_cnt=0 with no clock edge.
- Forwarding: EX SUBS gives alu_zero=1, ex_set_flags=1, while ID carries B.cond EQ(0000) → br_taken=1 next cycle; flags_q=0100 after the edge.
- Hold: EX ADD with ex_set_flags=0 and alu_zero=1, flags_q=0000, ID B.cond EQ → br_taken stays 0, flags_q unchanged.
- Signed conditions: flags_q N=1,V=0, then B.cond LT(1011) → taken. Same flags with GE(1010) → not taken. Flags N=1,V=1,Z=0 with GT(1100) → taken.
- Shadow squash:
  - CBZ with id_rt_zero=1, then B(01) on the next cycle → one br_taken pulse, squash=1 during the B, second branch not taken.
  - A flag-setting instruction in that shadow reaching EX does not update flags_q.
- Saturation: CNT_W=2, drive 5 taken branches (separated by non-branch cycles) → taken_cnt=3 holds; reset clears to 0.

Source files
------------

// File: rtl/flag_cond_unit.sv
// -----------------------------------------------------------------------------
// flag_cond_unit
//   Consumer end of the ALU flag interface. Captures NZCV from flag-setting EX
//   instructions into an architectural register, resolves B / B.cond / CBZ in
//   the ID stage (forwarding EX flags when a flag-setter sits directly ahead),
//   issues a registered one-cycle redirect and squashes the single shadow
//   instruction fetched behind a taken branch.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          asynchronous, active-high
//   alu_negative   EX-stage ALU N flag
//   alu_zero       EX-stage ALU Z flag
//   alu_overflow   EX-stage ALU V flag
//   alu_carry_out  EX-stage ALU C flag
//   ex_valid       EX holds a live instruction
//   ex_set_flags   EX instruction writes NZCV
//   id_valid       ID holds a live instruction
//   id_br_type     00 none, 01 B, 10 B.cond, 11 CBZ
//   id_cond        ARM condition code for B.cond
//   id_rt_zero     forwarded Rt==0 for CBZ
//   flags_q        architectural flags {N,Z,C,V}
//   br_taken       registered redirect to fetch, one-cycle pulse
//   squash         current ID instruction is a shadow and must be flushed
//   taken_cnt      saturating count of taken branches
// -----------------------------------------------------------------------------
module flag_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             id_valid,
  input  logic [1:0]       id_br_type,
  input  logic [3:0]       id_cond,
  input  logic             id_rt_zero,
  output logic [3:0]       flags_q,
  output logic             br_taken,
  output logic             squash,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_B    = 2'b01;
  localparam logic [1:0] BR_COND = 2'b10;
  localparam logic [1:0] BR_CBZ  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             br_taken_q, br_taken_d;
  logic             squash_ex_q;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       ex_flag_wr;
  logic [3:0] ex_flags;
  logic [3:0] eff_flags;
  logic       f_n, f_z, f_c, f_v;
  logic       cond_true;
  logic       take;

  // An EX instruction only counts as a flag writer if it is not the shadow of
  // a taken branch; the same qualifier gates both capture and forwarding.
  assign ex_flag_wr = ex_valid & ex_set_flags & ~squash_ex_q;
  assign ex_flags   = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
  assign eff_flags  = ex_flag_wr ? ex_flags : flags_q;
  assign flags_d    = eff_flags;

  assign f_n = eff_flags[3];
  assign f_z = eff_flags[2];
  assign f_c = eff_flags[1];
  assign f_v = eff_flags[0];

  // ARM condition code evaluation on the effective (possibly forwarded) flags
  always_comb begin
    cond_true = 1'b0;
    unique case (id_cond)
      4'b0000: cond_true = f_z;
      4'b0001: cond_true = ~f_z;
      4'b0010: cond_true = f_c;
      4'b0011: cond_true = ~f_c;
      4'b0100: cond_true = f_n;
      4'b0101: cond_true = ~f_n;
      4'b0110: cond_true = f_v;
      4'b0111: cond_true = ~f_v;
      4'b1000: cond_true = f_c & ~f_z;
      4'b1001: cond_true = ~f_c | f_z;
      4'b1010: cond_true = (f_n == f_v);
      4'b1011: cond_true = (f_n != f_v);
      4'b1100: cond_true = ~f_z & (f_n == f_v);
      4'b1101: cond_true = f_z | (f_n != f_v);
      default: cond_true = 1'b1;
    endcase
  end

  // ID branch decision; a shadow instruction can never be taken
  always_comb begin
    take = 1'b0;
    if (id_valid && !squash) begin
      unique case (id_br_type)
        BR_B:    take = 1'b1;
        BR_COND: take = cond_true;
        BR_CBZ:  take = id_rt_zero;
        BR_NONE: take = 1'b0;
        default: take = 1'b0;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. SHADOW lasts exactly one cycle whatever ID holds.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (take) state_d = ST_SHADOW;
      ST_SHADOW: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    squash     = (state_q == ST_SHADOW);
    br_taken_d = take;
  end

  // Count one per redirect pulse, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (br_taken_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      br_taken_q  <= 1'b0;
      squash_ex_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      flags_q     <= flags_d;
      br_taken_q  <= br_taken_d;
      squash_ex_q <= squash;
      cnt_q       <= cnt_d;
    end
  end

  assign br_taken  = br_taken_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic          ex_valid, ex_set_flags;
  logic          id_valid;
  logic [1:0]    id_br_type;
  logic [3:0]    id_cond;
  logic          id_rt_zero;
  logic [3:0]    flags_q;
  logic          br_taken;
  logic          squash;
  logic [CW-1:0] taken_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0]    m_flags;
  logic          m_br;
  logic          m_squash;     // previous cycle took a branch
  logic          m_squash_ex;  // took a branch two cycles ago
  logic [CW-1:0] m_cnt;

  flag_cond_unit #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .ex_valid      (ex_valid),
    .ex_set_flags  (ex_set_flags),
    .id_valid      (id_valid),
    .id_br_type    (id_br_type),
    .id_cond       (id_cond),
    .id_rt_zero    (id_rt_zero),
    .flags_q       (flags_q),
    .br_taken      (br_taken),
    .squash        (squash),
    .taken_cnt     (taken_cnt)
  );

  always #5 clk = ~clk;

  // Condition predicate from the ARM table; flags given as N,Z,C,V
  function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] nzcv);
    bit n, z, c, v;
    n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit branch_resolves(input logic [1:0] bt, input logic [3:0] cc,
                                         input logic rtz, input logic [3:0] nzcv);
    case (bt)
      2'b01:   return 1'b1;
      2'b10:   return cond_holds(cc, nzcv);
      2'b11:   return rtz;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_idle();
    alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
    ex_valid = 0; ex_set_flags = 0;
    id_valid = 0; id_br_type = 2'b00; id_cond = 4'b0000; id_rt_zero = 0;
  endtask

  task automatic set_ex(input logic vld, input logic setf, input logic [3:0] nzcv);
    ex_valid = vld; ex_set_flags = setf;
    alu_negative = nzcv[3]; alu_zero = nzcv[2]; alu_carry_out = nzcv[1]; alu_overflow = nzcv[0];
  endtask

  task automatic set_id(input logic vld, input logic [1:0] bt, input logic [3:0] cc, input logic rtz);
    id_valid = vld; id_br_type = bt; id_cond = cc; id_rt_zero = rtz;
  endtask

  task automatic model_clear();
    m_flags = 4'b0000; m_br = 0; m_squash = 0; m_squash_ex = 0; m_cnt = '0;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle
  task automatic tick();
    logic       fwd;
    logic [3:0] eff;
    logic       tk;
    fwd = ex_valid && ex_set_flags && !m_squash_ex;
    eff = fwd ? {alu_negative, alu_zero, alu_carry_out, alu_overflow} : m_flags;
    tk  = id_valid && !m_squash && branch_resolves(id_br_type, id_cond, id_rt_zero, eff);
    @(posedge clk); #1;
    m_flags = eff;
    if (m_br && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    m_br        = tk;
    m_squash_ex = m_squash;
    m_squash    = tk;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    // build up some state: take a branch while capturing flags
    set_ex(1, 1, 4'b1011);
    set_id(1, 2'b01, 4'b0000, 0);
    tick();
    set_idle();
    #2 reset = 1'b1;   // mid-SHADOW, no clock edge
    #1;
    model_clear();
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_br got=%b exp=0", br_taken); end
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL reset_squash got=%b exp=0", squash); end
    checks++; if (taken_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", taken_cnt); end
    $display("reset: async clear flags=%b br=%b squash=%b cnt=%0d", flags_q, br_taken, squash, taken_cnt);
    @(posedge clk); #1;
    reset = 1'b0;
    set_id(1, 2'b01, 4'b0000, 0);
    #1;
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL post_reset_squash got=%b exp=0", squash); end
    tick();
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL post_reset_take got=%b exp=1", br_taken); end
    $display("reset: first post-reset B br_taken=%b", br_taken);
    set_idle();
    tick();
  endtask

  task automatic test_forwarding();
    do_reset();
    set_ex(1, 1, 4'b0100);
    set_id(1, 2'b10, 4'b0000, 0);
    tick();
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL fwd_take got=%b exp=1", br_taken); end
    checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL fwd_flags got=%b exp=0100", flags_q); end
    $display("forwarding: SUBS Z=1 + B.EQ br_taken=%b flags=%b", br_taken, flags_q);
    set_idle();
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL fwd_pulse_width got=%b exp=0", br_taken); end
  endtask

  task automatic test_hold();
    do_reset();
    set_ex(1, 0, 4'b0100);
    set_id(1, 2'b10, 4'b0000, 0);
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL hold_take got=%b exp=0", br_taken); end
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL hold_flags got=%b exp=0000", flags_q); end
    $display("hold: ADD no-setflags + B.EQ br_taken=%b flags=%b", br_taken, flags_q);
    set_idle();
    tick();
  endtask

  task automatic test_signed();
    do_reset();
    set_ex(1, 1, 4'b1000);  // N=1 V=0
    tick();
    set_idle();
    set_id(1, 2'b10, 4'b1011, 0);  // LT
    tick();
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL signed_lt got=%b exp=1", br_taken); end
    $display("signed: N=1 V=0 LT br_taken=%b", br_taken);
    set_idle();
    tick();
    set_id(1, 2'b10, 4'b1010, 0);  // GE
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL signed_ge got=%b exp=0", br_taken); end
    $display("signed: N=1 V=0 GE br_taken=%b", br_taken);
    set_idle();
    set_ex(1, 1, 4'b1001);  // N=1 V=1 Z=0
    tick();
    set_idle();
    set_id(1, 2'b10, 4'b1100, 0);  // GT
    tick();
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL signed_gt got=%b exp=1", br_taken); end
    checks++; if (flags_q !== 4'b1001) begin errors++; $display("FAIL signed_flags got=%b exp=1001", flags_q); end
    $display("signed: N=1 V=1 Z=0 GT br_taken=%b", br_taken);
    set_idle();
    tick();
  endtask

  task automatic test_shadow();
    do_reset();
    set_id(1, 2'b11, 4'b0000, 1);  // CBZ, Rt==0
    tick();
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL shadow_cbz got=%b exp=1", br_taken); end
    set_id(1, 2'b01, 4'b0000, 0);  // B in the shadow
    #1;
    checks++; if (squash !== 1'b1) begin errors++; $display("FAIL shadow_squash got=%b exp=1", squash); end
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL shadow_second_b got=%b exp=0", br_taken); end
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL shadow_squash_len got=%b exp=0", squash); end
    $display("shadow: CBZ then B second br_taken=%b squash=%b", br_taken, squash);
    // the squashed instruction reaches EX trying to set flags
    set_idle();
    set_ex(1, 1, 4'b1111);
    tick();
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL shadow_flags got=%b exp=0000", flags_q); end
    $display("shadow: squashed flag-setter flags=%b", flags_q);
    // a normal flag-setter right after does write
    set_ex(1, 1, 4'b0110);
    tick();
    checks++; if (flags_q !== 4'b0110) begin errors++; $display("FAIL shadow_after_flags got=%b exp=0110", flags_q); end
    set_idle();
    tick();
    checks++; if (taken_cnt !== 1) begin errors++; $display("FAIL shadow_cnt got=%0d exp=1", taken_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 2'b01, 4'b0000, 0);
      tick();
      set_idle();
      tick();
      checks++;
      if (taken_cnt !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin
        errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, taken_cnt, (i + 1 > 3) ? 3 : i + 1);
      end
      $display("saturation: branch %0d taken_cnt=%0d", i, taken_cnt);
    end
    tick();
    checks++; if (taken_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", taken_cnt); end
    do_reset();
    checks++; if (taken_cnt !== 2'd0) begin errors++; $display("FAIL sat_reset got=%0d exp=0", taken_cnt); end
  endtask

  task automatic test_random();
    int local_err;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      local_err = 0;
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      set_id($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1);
      #1;
      checks++; if (squash !== m_squash) begin errors++; local_err++; $display("FAIL rnd_squash_pre[%0d] got=%b exp=%b", i, squash, m_squash); end
      tick();
      checks++; if (br_taken !== m_br) begin errors++; local_err++; $display("FAIL rnd_br[%0d] got=%b exp=%b", i, br_taken, m_br); end
      checks++; if (flags_q !== m_flags) begin errors++; local_err++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", i, flags_q, m_flags); end
      checks++; if (squash !== m_squash) begin errors++; local_err++; $display("FAIL rnd_squash[%0d] got=%b exp=%b", i, squash, m_squash); end
      checks++; if (taken_cnt !== m_cnt) begin errors++; local_err++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, taken_cnt, m_cnt); end
      $display("random %0d: br=%b flags=%b squash=%b cnt=%0d %s", i, br_taken, flags_q, squash, taken_cnt,
               (local_err == 0) ? "ok" : "bad");
      if (i % 97 == 96) do_reset();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    model_clear();
    #12;
    test_reset();
    test_forwarding();
    test_hold();
    test_signed();
    test_shadow();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
